// File: rtl/conv2x2_ctrl_pkg.sv
// Shared types and constants for the 2x2 convolution schedule controller.
//   state_e        : controller phase (idle, two passes split by a gap slot, done)
//   PASS_SLOTS     : slots per output-row pass
//   TAPS_PER_ROW   : real filter taps per 4-slot group (4th slot is zero padding)
//   GAP_INPUT_ADDR : input address presented in the single gap slot
//   SLOT_W         : width of the slot counter
package conv2x2_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPass0,
    StGap,
    StPass1,
    StDone
  } state_e;

  localparam int unsigned PASS_SLOTS     = 12;
  localparam int unsigned TAPS_PER_ROW   = 3;
  localparam int unsigned GAP_INPUT_ADDR = 4;
  localparam int unsigned SLOT_W         = 4;

endpackage

// File: rtl/conv2x2_tap_addr_gen.sv
// Combinational filter-tap address generator.
//   slot     in  SLOT_W  slot index j within a pass (0..11)
//   tap_addr out ADDR_W  filter address for slot j: ZERO_ADDR on the padding phase,
//                        otherwise FILT_BASE minus the running tap number
module conv2x2_tap_addr_gen
  import conv2x2_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned ZERO_ADDR = 25,
  parameter int unsigned FILT_BASE = 24
) (
  input  logic [SLOT_W-1:0] slot,
  output logic [ADDR_W-1:0] tap_addr
);

  logic [1:0]        phase;
  logic [1:0]        row;
  logic [ADDR_W-1:0] tap_idx;

  // Each 4-slot group carries TAPS_PER_ROW real taps followed by one padding slot.
  assign phase = slot[1:0];
  assign row   = slot[3:2];

  always_comb begin
    tap_idx = ADDR_W'(row) * ADDR_W'(TAPS_PER_ROW) + ADDR_W'(phase);
    if (phase >= 2'(TAPS_PER_ROW)) begin
      tap_addr = ADDR_W'(ZERO_ADDR);
    end else begin
      tap_addr = ADDR_W'(FILT_BASE) - tap_idx;
    end
  end

endmodule

// File: rtl/conv2x2_sched_ctrl.sv
// Address/enable sequencer for the 2x2 systolic convolution datapath.
// One start pulse runs 25 slots: pass 0 (row 0 via the first filter port), one gap
// slot, pass 1 (row 1 via the second filter port), then a one-cycle done pulse.
//   clk, rst           clock, synchronous active-high reset
//   start              run request, sampled only when idle
//   hold               stall; freezes slot and addresses while a run is active
//   busy, done         run in progress / one-cycle completion pulse
//   sys_2by2_en        datapath enable for each active, non-held slot
//   input_array_addr   input-array read address
//   filt_first_addr    filter address for the row-0 port
//   filt_second_addr   filter address for the row-1 port
//   buffer_read_addr   result-buffer index (C11,C12,C21,C22 = 0..3)
//   buffer_read_valid  buffer_read_addr is meaningful this slot
// All outputs are registered and reflect the slot entered at the last edge.
module conv2x2_sched_ctrl
  import conv2x2_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned ZERO_ADDR  = 25,
  parameter int unsigned FILT_BASE  = 24,
  parameter int unsigned IN_SIZE    = 16,
  parameter int unsigned P1_IN_BASE = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              sys_2by2_en,
  output logic [ADDR_W-1:0] input_array_addr,
  output logic [ADDR_W-1:0] filt_first_addr,
  output logic [ADDR_W-1:0] filt_second_addr,
  output logic [1:0]        buffer_read_addr,
  output logic              buffer_read_valid
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_ADDR);
  localparam logic [SLOT_W-1:0] LastSlot = SLOT_W'(PASS_SLOTS - 1);
  localparam logic [SLOT_W-1:0] RdSlot0  = SLOT_W'(PASS_SLOTS - 2);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              held;
  logic [ADDR_W-1:0] tap_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic [ADDR_W-1:0] p1_in;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    held    = hold && (state_q inside {StPass0, StGap, StPass1});
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StPass0;
          slot_d  = '0;
        end
      end
      StPass0: begin
        if (!held) begin
          if (slot_q == LastSlot) begin
            state_d = StGap;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      StGap: begin
        if (!held) state_d = StPass1;
      end
      StPass1: begin
        if (!held) begin
          if (slot_q == LastSlot) begin
            state_d = StDone;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Tap address is computed for the slot being entered so it can be registered with it.
  conv2x2_tap_addr_gen #(
    .ADDR_W   (ADDR_W),
    .ZERO_ADDR(ZERO_ADDR),
    .FILT_BASE(FILT_BASE)
  ) u_tap_addr_gen (
    .slot    (slot_d),
    .tap_addr(tap_addr)
  );

  // Pass-1 input addresses past the end of the input array read the zero word.
  assign p1_addr = ADDR_W'(P1_IN_BASE) + ADDR_W'(slot_d);
  assign p1_in   = (p1_addr >= ADDR_W'(IN_SIZE)) ? ZeroAddr : p1_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StIdle;
      slot_q            <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      sys_2by2_en       <= 1'b0;
      input_array_addr  <= ZeroAddr;
      filt_first_addr   <= ZeroAddr;
      filt_second_addr  <= ZeroAddr;
      buffer_read_addr  <= 2'd0;
      buffer_read_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      if (held) begin
        // Addresses and buffer index keep their values; only the strobes drop.
        sys_2by2_en       <= 1'b0;
        buffer_read_valid <= 1'b0;
      end else begin
        busy              <= 1'b0;
        done              <= 1'b0;
        sys_2by2_en       <= 1'b0;
        buffer_read_valid <= 1'b0;
        input_array_addr  <= ZeroAddr;
        filt_first_addr   <= ZeroAddr;
        filt_second_addr  <= ZeroAddr;
        unique case (state_d)
          StPass0: begin
            busy             <= 1'b1;
            sys_2by2_en      <= 1'b1;
            input_array_addr <= ADDR_W'(slot_d);
            filt_first_addr  <= tap_addr;
            if (slot_d >= RdSlot0) begin
              buffer_read_valid <= 1'b1;
              buffer_read_addr  <= {1'b0, slot_d == LastSlot};
            end
          end
          StGap: begin
            busy             <= 1'b1;
            sys_2by2_en      <= 1'b1;
            input_array_addr <= ADDR_W'(GAP_INPUT_ADDR);
          end
          StPass1: begin
            busy             <= 1'b1;
            sys_2by2_en      <= 1'b1;
            input_array_addr <= p1_in;
            filt_second_addr <= tap_addr;
            if (slot_d >= RdSlot0) begin
              buffer_read_valid <= 1'b1;
              buffer_read_addr  <= {1'b1, slot_d == LastSlot};
            end
          end
          StDone: done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
